// File: rtl/rob_multiport.sv
// -----------------------------------------------------------------------------
// rob_multiport -- reorder buffer for the Tomasulo core.
//
// Entries are allocated in order at the tail. Results arrive out of order on
// NUM_WB write-back (CDB) ports. Entries retire in order from the head, at most
// one per cycle. A store at the head waits for a memory handshake. A
// mispredicted branch at the head squashes every entry.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   alloc_valid/type/rd           allocation request from issue
//   alloc_ready, alloc_tag        entry available / tag of the entry (= tail)
//   wb_valid/tag/data/mispredict  NUM_WB write-back ports, flattened per port
//   entry_done                    per-tag result-valid vector (RS wake-up)
//   rd_tag_a/b -> rd_data_a/b     combinational operand lookup
//   commit_load/rd/data/tag       regfile write at retire
//   st_req, st_tag, st_ack        store handshake for the store at the head
//   flush, redirect_pc            one-cycle squash pulse with the new PC
// -----------------------------------------------------------------------------
module rob_multiport #(
    parameter  int DEPTH  = 8,
    parameter  int NUM_WB = 5,
    parameter  int XLEN   = 32,
    localparam int TAG_W  = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_valid,
    input  logic [1:0]              alloc_type,
    input  logic [4:0]              alloc_rd,
    output logic                    alloc_ready,
    output logic [TAG_W-1:0]        alloc_tag,
    input  logic [NUM_WB-1:0]       wb_valid,
    input  logic [NUM_WB*TAG_W-1:0] wb_tag,
    input  logic [NUM_WB*XLEN-1:0]  wb_data,
    input  logic [NUM_WB-1:0]       wb_mispredict,
    output logic [DEPTH-1:0]        entry_done,
    input  logic [TAG_W-1:0]        rd_tag_a,
    input  logic [TAG_W-1:0]        rd_tag_b,
    output logic [XLEN-1:0]         rd_data_a,
    output logic [XLEN-1:0]         rd_data_b,
    output logic                    commit_load,
    output logic [4:0]              commit_rd,
    output logic [XLEN-1:0]         commit_data,
    output logic [TAG_W-1:0]        commit_tag,
    output logic                    st_req,
    output logic [TAG_W-1:0]        st_tag,
    input  logic                    st_ack,
    output logic                    flush,
    output logic [XLEN-1:0]         redirect_pc
);

    localparam logic [1:0] T_ALU   = 2'd0;
    localparam logic [1:0] T_LOAD  = 2'd1;
    localparam logic [1:0] T_STORE = 2'd2;
    localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_RUN, S_ST_WAIT, S_FLUSH} state_t;

    state_t            r_state;
    state_t            w_state_next;
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [TAG_W:0]    r_head;
    logic [TAG_W:0]    r_tail;
    logic              r_valid [DEPTH];
    logic              r_done  [DEPTH];
    logic              r_mis   [DEPTH];
    logic [1:0]        r_type  [DEPTH];
    logic [4:0]        r_rd    [DEPTH];
    logic [XLEN-1:0]   r_data  [DEPTH];

    logic [TAG_W-1:0]  w_head_idx;
    logic [TAG_W-1:0]  w_tail_idx;
    logic              w_full;
    logic              w_head_ready;
    logic              w_flushing;
    logic              w_alloc;
    logic              w_commit;
    logic              w_retire;
    logic              w_st_req;
    logic              w_flush;
    logic              w_wb_conflict;

    assign w_head_idx   = r_head[TAG_W-1:0];
    assign w_tail_idx   = r_tail[TAG_W-1:0];
    assign w_full       = (w_head_idx == w_tail_idx) && (r_head[TAG_W] != r_tail[TAG_W]);
    assign w_head_ready = r_valid[w_head_idx] && r_done[w_head_idx];
    assign w_flushing   = w_flush || (r_state == S_FLUSH);
    assign w_alloc      = alloc_valid && alloc_ready;

    // Retire / store / squash decisions for the entry at the head.
    always_comb begin
        w_state_next = r_state;
        w_commit     = 1'b0;
        w_retire     = 1'b0;
        w_st_req     = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_head_ready) begin
                    case (r_type[w_head_idx])
                        T_ALU, T_LOAD: begin
                            w_commit = 1'b1;
                            w_retire = 1'b1;
                        end
                        T_STORE: begin
                            w_st_req     = 1'b1;
                            w_state_next = S_ST_WAIT;
                        end
                        default: begin
                            if (r_mis[w_head_idx]) begin
                                w_flush      = 1'b1;
                                w_state_next = S_FLUSH;
                            end else begin
                                w_retire = 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_ST_WAIT: begin
                w_st_req = 1'b1;
                if (st_ack) begin
                    w_retire     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_FLUSH: w_state_next = S_RUN;
            default: w_state_next = S_RUN;
        endcase
    end

    // Two write-back ports naming the same tag in one cycle is an upstream bug.
    always_comb begin
        w_wb_conflict = 1'b0;
        for (int a = 0; a < NUM_WB; a++) begin
            for (int b = a + 1; b < NUM_WB; b++) begin
                if (wb_valid[a] && wb_valid[b] &&
                    (wb_tag[a*TAG_W +: TAG_W] == wb_tag[b*TAG_W +: TAG_W])) begin
                    w_wb_conflict = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!w_wb_conflict);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_head  <= '0;
            r_tail  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_done[i]  <= 1'b0;
                r_mis[i]   <= 1'b0;
                r_type[i]  <= '0;
                r_rd[i]    <= '0;
                r_data[i]  <= '0;
            end
        end else begin
            r_state <= w_state_next;
            if (w_flush) begin
                // Squash: results arriving this cycle are discarded as well.
                r_head <= '0;
                r_tail <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    r_valid[i] <= 1'b0;
                    r_done[i]  <= 1'b0;
                end
            end else begin
                if (r_state != S_FLUSH) begin
                    // Descending order so the lowest port's write lands last and wins.
                    for (int p = NUM_WB - 1; p >= 0; p--) begin
                        if (wb_valid[p] && r_valid[wb_tag[p*TAG_W +: TAG_W]]) begin
                            r_data[wb_tag[p*TAG_W +: TAG_W]] <= wb_data[p*XLEN +: XLEN];
                            r_mis[wb_tag[p*TAG_W +: TAG_W]]  <= wb_mispredict[p];
                            r_done[wb_tag[p*TAG_W +: TAG_W]] <= 1'b1;
                        end
                    end
                end
                if (w_retire) begin
                    r_valid[w_head_idx] <= 1'b0;
                    r_head              <= r_head + PTR_ONE;
                end
                // alloc_ready is low when full, so tail never equals a live head here.
                if (w_alloc) begin
                    r_valid[w_tail_idx] <= 1'b1;
                    r_done[w_tail_idx]  <= 1'b0;
                    r_mis[w_tail_idx]   <= 1'b0;
                    r_type[w_tail_idx]  <= alloc_type;
                    r_rd[w_tail_idx]    <= alloc_rd;
                    r_tail              <= r_tail + PTR_ONE;
                end
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_done
        assign entry_done[gi] = r_valid[gi] & r_done[gi];
    end

    assign alloc_ready = !w_full && !w_flushing;
    assign alloc_tag   = w_tail_idx;
    assign rd_data_a   = r_data[rd_tag_a];
    assign rd_data_b   = r_data[rd_tag_b];
    assign commit_load = w_commit;
    assign commit_rd   = w_commit ? r_rd[w_head_idx] : '0;
    assign commit_data = w_commit ? r_data[w_head_idx] : '0;
    assign commit_tag  = w_commit ? w_head_idx : '0;
    assign st_req      = w_st_req;
    assign st_tag      = w_st_req ? w_head_idx : '0;
    assign flush       = w_flush;
    assign redirect_pc = w_flush ? r_data[w_head_idx] : '0;

endmodule

// File: tb/tb_rob_multiport.sv
// -----------------------------------------------------------------------------
// tb_rob_multiport -- self-checking bench for rob_multiport.
// A vector table covers in-order commit after out-of-order and parallel
// write-back; directed sequences cover fill, store handshake, reset during a
// store, mispredict squash and pointer wrap; a random phase runs against a
// queue-based reference model of the buffer.
// -----------------------------------------------------------------------------
module tb_rob_multiport;
    localparam int DEPTH  = 8;
    localparam int NUM_WB = 5;
    localparam int XLEN   = 32;
    localparam int TAG_W  = 3;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    alloc_valid;
    logic [1:0]              alloc_type;
    logic [4:0]              alloc_rd;
    logic                    alloc_ready;
    logic [TAG_W-1:0]        alloc_tag;
    logic [NUM_WB-1:0]       wb_valid;
    logic [NUM_WB*TAG_W-1:0] wb_tag;
    logic [NUM_WB*XLEN-1:0]  wb_data;
    logic [NUM_WB-1:0]       wb_mispredict;
    logic [DEPTH-1:0]        entry_done;
    logic [TAG_W-1:0]        rd_tag_a, rd_tag_b;
    logic [XLEN-1:0]         rd_data_a, rd_data_b;
    logic                    commit_load;
    logic [4:0]              commit_rd;
    logic [XLEN-1:0]         commit_data;
    logic [TAG_W-1:0]        commit_tag;
    logic                    st_req;
    logic [TAG_W-1:0]        st_tag;
    logic                    st_ack;
    logic                    flush;
    logic [XLEN-1:0]         redirect_pc;

    always #5 clk = ~clk;

    rob_multiport #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_mispredict(wb_mispredict),
        .entry_done(entry_done),
        .rd_tag_a(rd_tag_a), .rd_tag_b(rd_tag_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .commit_load(commit_load), .commit_rd(commit_rd), .commit_data(commit_data),
        .commit_tag(commit_tag),
        .st_req(st_req), .st_tag(st_tag), .st_ack(st_ack),
        .flush(flush), .redirect_pc(redirect_pc)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: in-order list of live entries --------
    typedef struct {
        int          tag;
        logic [1:0]  ty;
        logic [4:0]  rd;
        logic        done;
        logic [31:0] data;
        logic        mis;
    } ent_t;

    ent_t        q[$];
    int          m_next_tag;
    bit          m_wait;   // a store at the head is waiting for its ack
    bit          m_hold;   // the cycle after a squash
    logic [31:0] m_data [DEPTH];

    task automatic model_reset();
        q.delete();
        m_next_tag = 0;
        m_wait     = 1'b0;
        m_hold     = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_data[i] = '0;
    endtask

    task automatic clear_inputs();
        alloc_valid   = 1'b0;
        alloc_type    = 2'd0;
        alloc_rd      = 5'd0;
        wb_valid      = '0;
        wb_tag        = '0;
        wb_data       = '0;
        wb_mispredict = '0;
        rd_tag_a      = '0;
        rd_tag_b      = '0;
        st_ack        = 1'b0;
    endtask

    task automatic set_alloc(input int ty, input int rd);
        alloc_valid = 1'b1;
        alloc_type  = ty[1:0];
        alloc_rd    = rd[4:0];
    endtask

    task automatic set_wb(input int p, input int tag, input logic [31:0] d, input logic m);
        wb_valid[p]                 = 1'b1;
        wb_tag[p*TAG_W +: TAG_W]    = tag[TAG_W-1:0];
        wb_data[p*XLEN +: XLEN]     = d;
        wb_mispredict[p]            = m;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Compare every output with the model, clock once, advance the model.
    task automatic step();
        ent_t        h;
        bit          hv, hd, e_flush, e_cl, e_silent, e_stq, e_ready, e_ret;
        logic [7:0]  e_done;
        int          t;
        #1;
        hv = (q.size() > 0);
        if (hv) h = q[0];
        else    h = '{0, 2'd0, 5'd0, 1'b0, 32'd0, 1'b0};
        hd       = !m_wait && !m_hold && hv && h.done;
        e_flush  = hd && (h.ty == 2'd3) && h.mis;
        e_silent = hd && (h.ty == 2'd3) && !h.mis;
        e_cl     = hd && (h.ty == 2'd0 || h.ty == 2'd1);
        e_stq    = m_wait || (hd && h.ty == 2'd2);
        e_ready  = (q.size() < DEPTH) && !e_flush && !m_hold;
        e_done   = '0;
        foreach (q[k]) if (q[k].done) e_done[q[k].tag] = 1'b1;

        chk("alloc_ready", alloc_ready, e_ready);
        chk("alloc_tag", alloc_tag, m_next_tag);
        chk("entry_done", entry_done, e_done);
        chk("commit_load", commit_load, e_cl);
        chk("commit_rd", commit_rd, e_cl ? h.rd : 5'd0);
        chk("commit_data", commit_data, e_cl ? h.data : 32'd0);
        chk("commit_tag", commit_tag, e_cl ? h.tag : 0);
        chk("st_req", st_req, e_stq);
        chk("st_tag", st_tag, e_stq ? h.tag : 0);
        chk("flush", flush, e_flush);
        chk("redirect_pc", redirect_pc, e_flush ? h.data : 32'd0);
        chk("rd_data_a", rd_data_a, m_data[rd_tag_a]);
        chk("rd_data_b", rd_data_b, m_data[rd_tag_b]);

        if (e_cl)    $display("commit tag=%0d rd=%0d data=%h", h.tag, h.rd, h.data);
        if (e_flush) $display("flush tag=%0d redirect=%h", h.tag, h.data);
        e_ret = e_cl || e_silent || (m_wait && st_ack);
        if (m_wait && st_ack && !rst) $display("store retired tag=%0d", h.tag);

        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else if (e_flush) begin
            q.delete();
            m_next_tag = 0;
            m_hold     = 1'b1;
        end else begin
            m_hold = 1'b0;
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p]) begin
                    t = int'(wb_tag[p*TAG_W +: TAG_W]);
                    foreach (q[k]) begin
                        if (q[k].tag == t) begin
                            q[k].done = 1'b1;
                            q[k].data = wb_data[p*XLEN +: XLEN];
                            q[k].mis  = wb_mispredict[p];
                            m_data[t] = wb_data[p*XLEN +: XLEN];
                        end
                    end
                end
            end
            if (e_ret) begin
                void'(q.pop_front());
                m_wait = 1'b0;
            end else if (e_stq) begin
                m_wait = 1'b1;
            end
            if (alloc_valid && e_ready) begin
                q.push_back('{m_next_tag, alloc_type, alloc_rd, 1'b0, 32'd0, 1'b0});
                m_next_tag = (m_next_tag + 1) % DEPTH;
            end
        end
    endtask

    // ---------------- vector table ------------------------------------------
    typedef struct {
        bit          pre_rst;
        bit          av;
        logic [4:0]  ard;
        logic [3:0]  wbv;     // ports 0..3
        logic [11:0] wtag;    // 3 bits per port
        logic [31:0] wdat;    // 8 bits per port
        logic [2:0]  e_tag;
        logic [7:0]  e_done;
        bit          e_cl;
        logic [4:0]  e_rd;
        logic [31:0] e_cd;
    } vec_t;

    vec_t vt [19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int commits;
        int t;
        bit [7:0] used;

        // Out-of-order write-back: tags 2,0,1 complete, commits come out 0,1,2.
        vt[0]  = '{0, 1, 5'd1, 4'h0, 12'h000, 32'h00,       3'd0, 8'h00, 0, 5'd0, 32'h00};
        vt[1]  = '{0, 1, 5'd2, 4'h0, 12'h000, 32'h00,       3'd1, 8'h00, 0, 5'd0, 32'h00};
        vt[2]  = '{0, 1, 5'd3, 4'h0, 12'h000, 32'h00,       3'd2, 8'h00, 0, 5'd0, 32'h00};
        vt[3]  = '{0, 0, 5'd0, 4'h1, 12'h002, 32'h33,       3'd3, 8'h00, 0, 5'd0, 32'h00};
        vt[4]  = '{0, 0, 5'd0, 4'h1, 12'h000, 32'h11,       3'd3, 8'h04, 0, 5'd0, 32'h00};
        vt[5]  = '{0, 0, 5'd0, 4'h1, 12'h001, 32'h22,       3'd3, 8'h05, 1, 5'd1, 32'h11};
        vt[6]  = '{0, 0, 5'd0, 4'h0, 12'h000, 32'h00,       3'd3, 8'h06, 1, 5'd2, 32'h22};
        vt[7]  = '{0, 0, 5'd0, 4'h0, 12'h000, 32'h00,       3'd3, 8'h04, 1, 5'd3, 32'h33};
        vt[8]  = '{0, 0, 5'd0, 4'h0, 12'h000, 32'h00,       3'd3, 8'h00, 0, 5'd0, 32'h00};
        // Parallel write-back on ports 0..3 to tags 0..3, then four commits.
        vt[9]  = '{1, 1, 5'd5, 4'h0, 12'h000, 32'h00,       3'd0, 8'h00, 0, 5'd0, 32'h00};
        vt[10] = '{0, 1, 5'd6, 4'h0, 12'h000, 32'h00,       3'd1, 8'h00, 0, 5'd0, 32'h00};
        vt[11] = '{0, 1, 5'd7, 4'h0, 12'h000, 32'h00,       3'd2, 8'h00, 0, 5'd0, 32'h00};
        vt[12] = '{0, 1, 5'd8, 4'h0, 12'h000, 32'h00,       3'd3, 8'h00, 0, 5'd0, 32'h00};
        vt[13] = '{0, 0, 5'd0, 4'hF, 12'h688, 32'hA3A2A1A0, 3'd4, 8'h00, 0, 5'd0, 32'h00};
        vt[14] = '{0, 0, 5'd0, 4'h0, 12'h000, 32'h00,       3'd4, 8'h0F, 1, 5'd5, 32'hA0};
        vt[15] = '{0, 0, 5'd0, 4'h0, 12'h000, 32'h00,       3'd4, 8'h0E, 1, 5'd6, 32'hA1};
        vt[16] = '{0, 0, 5'd0, 4'h0, 12'h000, 32'h00,       3'd4, 8'h0C, 1, 5'd7, 32'hA2};
        vt[17] = '{0, 0, 5'd0, 4'h0, 12'h000, 32'h00,       3'd4, 8'h08, 1, 5'd8, 32'hA3};
        vt[18] = '{0, 0, 5'd0, 4'h0, 12'h000, 32'h00,       3'd4, 8'h00, 0, 5'd0, 32'h00};

        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 19; i++) begin
            if (vt[i].pre_rst) do_reset();
            clear_inputs();
            alloc_valid = vt[i].av;
            alloc_rd    = vt[i].ard;
            wb_valid    = {1'b0, vt[i].wbv};
            for (int p = 0; p < 4; p++) begin
                wb_tag[p*TAG_W +: TAG_W] = vt[i].wtag[p*3 +: 3];
                wb_data[p*XLEN +: XLEN]  = {24'h0, vt[i].wdat[p*8 +: 8]};
            end
            #1;
            $display("vec %0d alloc_tag=%0d done=%h commit=%0d rd=%0d data=%h",
                     i, alloc_tag, entry_done, commit_load, commit_rd, commit_data);
            chk("vec_ready", alloc_ready, 1'b1);
            chk("vec_tag", alloc_tag, vt[i].e_tag);
            chk("vec_done", entry_done, vt[i].e_done);
            chk("vec_commit", commit_load, vt[i].e_cl);
            chk("vec_rd", commit_rd, vt[i].e_rd);
            chk("vec_data", commit_data, vt[i].e_cd);
            @(posedge clk);
            #1;
        end

        // Fill: tags 0..7, then full, and a ninth request is ignored.
        do_reset();
        clear_inputs();
        #1;
        chk("reset_ready", alloc_ready, 1'b1);
        chk("reset_flush", flush, 1'b0);
        step();
        for (int i = 0; i < DEPTH; i++) begin
            clear_inputs();
            set_alloc(0, i + 1);
            #1;
            chk("fill_tag", alloc_tag, i);
            step();
        end
        clear_inputs();
        set_alloc(0, 9);
        #1;
        chk("full_ready", alloc_ready, 1'b0);
        step();
        clear_inputs();
        #1;
        chk("full_still", alloc_ready, 1'b0);
        chk("full_tag", alloc_tag, 0);
        step();

        // Store handshake: st_req held until st_ack, no regfile write.
        do_reset();
        clear_inputs(); set_alloc(2, 0); step();
        clear_inputs(); set_wb(0, 0, 32'h5, 1'b0); step();
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            #1;
            chk("st_hold", st_req, 1'b1);
            chk("st_hold_tag", st_tag, 0);
            chk("st_no_commit", commit_load, 1'b0);
            step();
        end
        clear_inputs(); st_ack = 1'b1;
        #1;
        chk("st_ack_cycle", st_req, 1'b1);
        step();
        clear_inputs();
        #1;
        chk("st_retired", st_req, 1'b0);
        chk("st_done_clr", entry_done, 8'h00);
        step();

        // Reset while waiting for a store ack; a late ack is ignored.
        do_reset();
        clear_inputs(); set_alloc(2, 0); step();
        clear_inputs(); set_wb(1, 0, 32'h7, 1'b0); step();
        clear_inputs(); step();
        clear_inputs(); rst = 1'b1; st_ack = 1'b1; step();
        rst = 1'b0;
        clear_inputs(); st_ack = 1'b1;
        #1;
        chk("rst_st_req", st_req, 1'b0);
        chk("rst_ready", alloc_ready, 1'b1);
        step();

        // Mispredict at the head squashes younger completed entries.
        do_reset();
        clear_inputs(); set_alloc(3, 0); step();
        clear_inputs(); set_alloc(0, 4); step();
        clear_inputs(); set_alloc(0, 5); step();
        clear_inputs();
        set_wb(4, 0, 32'h80, 1'b1);
        set_wb(0, 1, 32'h41, 1'b0);
        set_wb(1, 2, 32'h42, 1'b0);
        step();
        clear_inputs(); set_wb(0, 1, 32'hDEAD, 1'b0);
        #1;
        chk("mp_flush", flush, 1'b1);
        chk("mp_redirect", redirect_pc, 32'h80);
        chk("mp_ready", alloc_ready, 1'b0);
        step();
        clear_inputs(); set_alloc(0, 6); rd_tag_a = 3'd1;
        #1;
        chk("mp_pulse", flush, 1'b0);
        chk("mp_hold_ready", alloc_ready, 1'b0);
        chk("mp_no_commit", commit_load, 1'b0);
        chk("mp_done_clr", entry_done, 8'h00);
        chk("mp_wb_dropped", rd_data_a, 32'h41);
        step();
        clear_inputs(); set_alloc(0, 6);
        #1;
        chk("mp_next_tag", alloc_tag, 0);
        chk("mp_ready_again", alloc_ready, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            #1;
            chk("mp_quiet", commit_load, 1'b0);
            step();
        end

        // Wrap: keep the buffer full while retiring 20 entries in order.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            clear_inputs(); set_alloc(0, i + 1); step();
        end
        commits = 0;
        for (int cyc = 0; cyc < 300 && commits < 20; cyc++) begin
            clear_inputs();
            set_alloc(int'($urandom_range(0, 1)), int'($urandom_range(1, 31)));
            if (q.size() > 0 && !q[0].done) set_wb(0, q[0].tag, 32'h100 + cyc, 1'b0);
            #1;
            if (commit_load) begin
                chk("wrap_tag", commit_tag, commits % DEPTH);
                commits++;
            end
            step();
        end
        chk("wrap_count", commits, 20);

        // Random traffic against the model.
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            clear_inputs();
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) < 7) set_alloc(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)));
            used = '0;
            for (int p = 0; p < NUM_WB; p++) begin
                if ($urandom_range(0, 9) < 4) begin
                    t = int'($urandom_range(0, DEPTH - 1));
                    while (used[t]) t = (t + 1) % DEPTH;
                    used[t] = 1'b1;
                    set_wb(p, t, $urandom, (p == NUM_WB - 1) && ($urandom_range(0, 3) == 0));
                end
            end
            st_ack   = ($urandom_range(0, 2) == 0);
            rd_tag_a = TAG_W'($urandom_range(0, DEPTH - 1));
            rd_tag_b = TAG_W'($urandom_range(0, DEPTH - 1));
            step();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
